// File: rtl/npc_mem_pkg.sv
// Shared definitions for the PMem initiator: access-size encodings and LSU FSM states.
package npc_mem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Load/store unit memory-master states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Purely combinational sub-word alignment: store lane shift/mask, misalignment
// detection and load lane extraction with sign/zero extension.
module lsu_align
    import npc_mem_pkg::*;
(
    input  logic [1:0]  byteOff_i,
    input  logic [1:0]  size_i,
    input  logic        wen_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic [31:0] ldata_o
);

    logic [4:0]  shamt;
    logic [31:0] rdShifted;

    // Shift store data into its byte lanes, build the lane mask, flag illegal
    // alignments and pull the addressed lanes out of the read word.
    always_comb begin
        shamt      = {byteOff_i, 3'b000};
        wdata_o    = wdata_i << shamt;
        rdShifted  = rdata_i >> shamt;
        misalign_o = 1'b0;
        wmask_o    = 4'b0000;
        ldata_o    = rdShifted;

        case (size_i)
            SIZE_B:  misalign_o = 1'b0;
            SIZE_H:  misalign_o = byteOff_i[0];
            SIZE_W:  misalign_o = (byteOff_i != 2'b00);
            default: misalign_o = 1'b1;
        endcase

        if (wen_i) begin
            case (size_i)
                SIZE_B:  wmask_o = 4'b0001 << byteOff_i;
                SIZE_H:  wmask_o = 4'b0011 << byteOff_i;
                SIZE_W:  wmask_o = 4'b1111;
                default: wmask_o = 4'b0000;
            endcase
        end

        case (size_i)
            SIZE_B:  ldata_o = {{24{signed_i & rdShifted[7]}}, rdShifted[7:0]};
            SIZE_H:  ldata_o = {{16{signed_i & rdShifted[15]}}, rdShifted[15:0]};
            default: ldata_o = rdShifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// PMem initiator for the LSU: takes one load/store at a time, runs it on the
// memory port for ACCESS_CYCLES cycles and holds the response until consumed.
module lsu_mem_master
    import npc_mem_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata
);

    localparam int              CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       size_q, size_d;
    logic             signed_q, signed_d;
    logic             wen_q, wen_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             inIdle;
    logic             inAccess;
    logic             lastCycle;
    logic [1:0]       alignOff;
    logic [1:0]       alignSize;
    logic             alignWen;
    logic             alignSigned;
    logic [31:0]      alignWdataIn;
    logic [3:0]       alignMask;
    logic [31:0]      alignWdata;
    logic             alignMisalign;
    logic [31:0]      alignLdata;

    // The aligner looks at the incoming request while idle (to classify it on
    // accept) and at the registered request otherwise (to drive the port).
    always_comb begin
        inIdle       = (state_q == IDLE);
        inAccess     = (state_q == ACCESS);
        lastCycle    = inAccess && (cnt_q == CNT_LAST);
        alignOff     = inIdle ? req_addr[1:0] : addr_q[1:0];
        alignSize    = inIdle ? req_size      : size_q;
        alignWen     = inIdle ? req_wen       : wen_q;
        alignSigned  = inIdle ? req_signed    : signed_q;
        alignWdataIn = inIdle ? req_wdata     : wdata_q;
    end

    lsu_align u_align (
        .byteOff_i  (alignOff),
        .size_i     (alignSize),
        .wen_i      (alignWen),
        .signed_i   (alignSigned),
        .wdata_i    (alignWdataIn),
        .rdata_i    (mem_rdata),
        .wmask_o    (alignMask),
        .wdata_o    (alignWdata),
        .misalign_o (alignMisalign),
        .ldata_o    (alignLdata)
    );

    // Next-state logic: capture on accept, count access cycles, sample load
    // data on the final access cycle, release on response handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        signed_d = signed_q;
        wen_d    = wen_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    size_d   = req_size;
                    signed_d = req_signed;
                    wen_d    = req_wen;
                    rdata_d  = 32'h0;
                    err_d    = alignMisalign;
                    cnt_d    = '0;
                    state_d  = alignMisalign ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (lastCycle) begin
                    if (!wen_q) begin
                        rdata_d = alignLdata;
                    end
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; synchronous reset drops any in-flight request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            wen_q    <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wen_q    <= wen_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Port outputs: memory signals are only non-zero during ACCESS, and the
    // write strobe fires once, on the last access cycle of a store.
    always_comb begin
        req_ready  = inIdle;
        resp_valid = (state_q == RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_valid  = inAccess;
        mem_raddr  = inAccess ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_waddr  = inAccess ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wdata  = inAccess ? alignWdata : 32'h0;
        mem_wmask  = inAccess ? {4'b0000, alignMask} : 8'h00;
        mem_wen    = lastCycle && wen_q;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: DUT A (ACCESS_CYCLES=1) runs directed loads/stores
// against a small memory model; DUT B (ACCESS_CYCLES=3) covers multi-cycle
// access, response back-pressure and reset during ACCESS.
module tb_lsu_mem_master;
    import npc_mem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  mask;
    } wr_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        aReset, aReqValid, aReqReady, aReqWen, aReqSigned;
    logic [31:0] aReqAddr, aReqWdata;
    logic [1:0]  aReqSize;
    logic        aRespValid, aRespReady, aRespErr;
    logic [31:0] aRespRdata;
    logic        aMemValid, aMemWen;
    logic [31:0] aMemRaddr, aMemWaddr, aMemWdata, aMemRdata;
    logic [7:0]  aMemWmask;

    logic        bReset, bReqValid, bReqReady, bReqWen, bReqSigned;
    logic [31:0] bReqAddr, bReqWdata;
    logic [1:0]  bReqSize;
    logic        bRespValid, bRespReady, bRespErr;
    logic [31:0] bRespRdata;
    logic        bMemValid, bMemWen;
    logic [31:0] bMemRaddr, bMemWaddr, bMemWdata, bMemRdata;
    logic [7:0]  bMemWmask;

    int    checks   = 0;
    int    failures = 0;
    resp_t aRespQ[$];
    resp_t bRespQ[$];
    wr_t   aWrQ[$];
    resp_t aExp, bExp;
    wr_t   aExpWr;
    logic [31:0] memA [16];

    lsu_mem_master #(.ACCESS_CYCLES(1)) dutA (
        .clock(clock), .reset(aReset),
        .req_valid(aReqValid), .req_ready(aReqReady), .req_wen(aReqWen),
        .req_addr(aReqAddr), .req_wdata(aReqWdata), .req_size(aReqSize),
        .req_signed(aReqSigned), .resp_valid(aRespValid), .resp_ready(aRespReady),
        .resp_rdata(aRespRdata), .resp_err(aRespErr), .mem_valid(aMemValid),
        .mem_raddr(aMemRaddr), .mem_waddr(aMemWaddr), .mem_wdata(aMemWdata),
        .mem_wmask(aMemWmask), .mem_wen(aMemWen), .mem_rdata(aMemRdata)
    );

    lsu_mem_master #(.ACCESS_CYCLES(3)) dutB (
        .clock(clock), .reset(bReset),
        .req_valid(bReqValid), .req_ready(bReqReady), .req_wen(bReqWen),
        .req_addr(bReqAddr), .req_wdata(bReqWdata), .req_size(bReqSize),
        .req_signed(bReqSigned), .resp_valid(bRespValid), .resp_ready(bRespReady),
        .resp_rdata(bRespRdata), .resp_err(bRespErr), .mem_valid(bMemValid),
        .mem_raddr(bMemRaddr), .mem_waddr(bMemWaddr), .mem_wdata(bMemWdata),
        .mem_wmask(bMemWmask), .mem_wen(bMemWen), .mem_rdata(bMemRdata)
    );

    // Combinational PMem read for both DUTs; B sees a fixed word.
    assign aMemRdata = aMemValid ? memA[aMemRaddr[5:2]] : 32'h0;
    assign bMemRdata = bMemValid ? 32'h11223344 : 32'h0;

    // Memory model for A: preloaded under reset, byte-masked writes on mem_wen.
    always @(posedge clock) begin
        if (aReset) begin
            for (int i = 0; i < 16; i++) memA[i] <= (i == 1) ? 32'h80112233 : 32'h0;
        end else if (aMemWen) begin
            for (int i = 0; i < 4; i++)
                if (aMemWmask[i]) memA[aMemWaddr[5:2]][8*i +: 8] <= aMemWdata[8*i +: 8];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic flagFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=event required=none", name);
    endtask

    // Monitor A: compare every accepted response and every write strobe
    // against the expectations queued by the stimulus.
    always @(negedge clock) begin
        if (!aReset) begin
            if (aRespValid && aRespReady) begin
                if (aRespQ.size() == 0) flagFail("unexpectedRespA");
                else begin
                    aExp = aRespQ.pop_front();
                    checkOutput("respRdataA", aRespRdata, aExp.rdata);
                    checkOutput("respErrA", 32'(aRespErr), 32'(aExp.err));
                end
            end
            if (aMemWen) begin
                if (aWrQ.size() == 0) flagFail("unexpectedWriteA");
                else begin
                    aExpWr = aWrQ.pop_front();
                    checkOutput("memWaddrA", aMemWaddr, aExpWr.addr);
                    checkOutput("memWdataA", aMemWdata, aExpWr.data);
                    checkOutput("memWmaskA", 32'(aMemWmask), 32'(aExpWr.mask));
                end
            end
        end
    end

    // Monitor B: accepted responses only.
    always @(negedge clock) begin
        if (!bReset && bRespValid && bRespReady) begin
            if (bRespQ.size() == 0) flagFail("unexpectedRespB");
            else begin
                bExp = bRespQ.pop_front();
                checkOutput("respRdataB", bRespRdata, bExp.rdata);
                checkOutput("respErrB", 32'(bRespErr), 32'(bExp.err));
            end
        end
    end

    // Issue one request to DUT A, queue its expected response/write, check
    // latency around accept, then wait for the response to drain.
    task automatic applyStimulus(input string name, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input logic [31:0] expWaddr, input logic [31:0] expWdata,
                                 input logic [7:0] expMask);
        int n;
        aRespQ.push_back('{rdata: expRdata, err: expErr});
        if (wen && !expErr) aWrQ.push_back('{addr: expWaddr, data: expWdata, mask: expMask});
        aReqValid = 1'b1; aReqWen = wen; aReqAddr = addr; aReqWdata = wdata;
        aReqSize = size; aReqSigned = sgn;
        n = 0;
        while (!aReqReady && n < 50) begin @(posedge clock); #1; n++; end
        if (n >= 50) flagFail({name, "_acceptTimeout"});
        @(posedge clock); #1;
        aReqValid = 1'b0; aReqAddr = 32'hFFFFFFFF; aReqWdata = 32'hFFFFFFFF; aReqSize = 2'd3;
        if (expErr) begin
            checkOutput({name, "_errRespValid"}, 32'(aRespValid), 32'd1);
            checkOutput({name, "_errMemValid"}, 32'(aMemValid), 32'd0);
        end else begin
            checkOutput({name, "_memValid"}, 32'(aMemValid), 32'd1);
            checkOutput({name, "_memWen"}, 32'(aMemWen), 32'(wen));
            checkOutput({name, "_memRaddr"}, aMemRaddr, expWaddr);
            checkOutput({name, "_earlyResp"}, 32'(aRespValid), 32'd0);
            @(posedge clock); #1;
            checkOutput({name, "_respValid"}, 32'(aRespValid), 32'd1);
            checkOutput({name, "_memIdle"}, 32'(aMemValid), 32'd0);
        end
        n = 0;
        while (aRespQ.size() != 0 && n < 50) begin @(posedge clock); #1; n++; end
        if (n >= 50) flagFail({name, "_respTimeout"});
        checkOutput({name, "_reqReadyAfter"}, 32'(aReqReady), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aReset = 1'b1; aReqValid = 1'b0; aReqWen = 1'b0; aReqAddr = '0; aReqWdata = '0;
        aReqSize = '0; aReqSigned = 1'b0; aRespReady = 1'b1;
        bReset = 1'b1; bReqValid = 1'b0; bReqWen = 1'b0; bReqAddr = '0; bReqWdata = '0;
        bReqSize = '0; bReqSigned = 1'b0; bRespReady = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        aReset = 1'b0; bReset = 1'b0;

        checkOutput("rstReqReady", 32'(aReqReady), 32'd1);
        checkOutput("rstRespValid", 32'(aRespValid), 32'd0);
        checkOutput("rstMemValid", 32'(aMemValid), 32'd0);
        checkOutput("rstMemWen", 32'(aMemWen), 32'd0);
        checkOutput("rstMemRaddr", aMemRaddr, 32'h0);
        checkOutput("rstRespRdata", aRespRdata, 32'h0);

        // Loads against preloaded word 0x80112233 at 0x80000004
        applyStimulus("LB",   1'b0, 32'h80000007, 32'h0, SIZE_B, 1'b1, 32'hFFFFFF80, 1'b0, 32'h80000004, 32'h0, 8'h00);
        applyStimulus("LBU",  1'b0, 32'h80000007, 32'h0, SIZE_B, 1'b0, 32'h00000080, 1'b0, 32'h80000004, 32'h0, 8'h00);
        applyStimulus("LH",   1'b0, 32'h80000006, 32'h0, SIZE_H, 1'b1, 32'hFFFF8011, 1'b0, 32'h80000004, 32'h0, 8'h00);
        applyStimulus("LHU",  1'b0, 32'h80000006, 32'h0, SIZE_H, 1'b0, 32'h00008011, 1'b0, 32'h80000004, 32'h0, 8'h00);
        applyStimulus("LW",   1'b0, 32'h80000004, 32'h0, SIZE_W, 1'b1, 32'h80112233, 1'b0, 32'h80000004, 32'h0, 8'h00);
        applyStimulus("LBU0", 1'b0, 32'h80000004, 32'h0, SIZE_B, 1'b0, 32'h00000033, 1'b0, 32'h80000004, 32'h0, 8'h00);
        // Misaligned / illegal
        applyStimulus("LHmis", 1'b0, 32'h80000003, 32'h0, SIZE_H, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0, 8'h00);
        applyStimulus("LWmis", 1'b0, 32'h80000002, 32'h0, SIZE_W, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 8'h00);
        applyStimulus("SZ3",   1'b0, 32'h80000004, 32'h0, 2'd3,   1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 8'h00);
        // Stores
        applyStimulus("SW", 1'b1, 32'h80000004, 32'hDEADBEEF, SIZE_W, 1'b0, 32'h0, 1'b0, 32'h80000004, 32'hDEADBEEF, 8'h0F);
        applyStimulus("SB", 1'b1, 32'h80000006, 32'h000000A5, SIZE_B, 1'b0, 32'h0, 1'b0, 32'h80000004, 32'h00A50000, 8'h04);
        applyStimulus("SH", 1'b1, 32'h80000002, 32'h00001234, SIZE_H, 1'b0, 32'h0, 1'b0, 32'h80000000, 32'h12340000, 8'h0C);
        applyStimulus("SHmis", 1'b1, 32'h80000001, 32'h00005678, SIZE_H, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 8'h00);
        // Read back what the stores left in memory
        applyStimulus("LWback", 1'b0, 32'h80000004, 32'h0, SIZE_W, 1'b0, 32'hDEA5BEEF, 1'b0, 32'h80000004, 32'h0, 8'h00);
        applyStimulus("LWback0", 1'b0, 32'h80000000, 32'h0, SIZE_W, 1'b0, 32'h12340000, 1'b0, 32'h80000000, 32'h0, 8'h00);
        applyStimulus("LHback", 1'b0, 32'h80000002, 32'h0, SIZE_H, 1'b1, 32'h00001234, 1'b0, 32'h80000000, 32'h0, 8'h00);
        checkOutput("wrQueueEmptyA", 32'(aWrQ.size()), 32'd0);

        // DUT B: three-cycle store with response back-pressure
        bRespQ.push_back('{rdata: 32'h0, err: 1'b0});
        bReqValid = 1'b1; bReqWen = 1'b1; bReqAddr = 32'h80000008; bReqWdata = 32'h0BADF00D;
        bReqSize = SIZE_W;
        checkOutput("B_reqReadyIdle", 32'(bReqReady), 32'd1);
        @(posedge clock); #1;
        bReqValid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            checkOutput($sformatf("B_memValid%0d", k), 32'(bMemValid), 32'd1);
            checkOutput($sformatf("B_memWen%0d", k), 32'(bMemWen), (k == 3) ? 32'd1 : 32'd0);
            checkOutput($sformatf("B_reqReady%0d", k), 32'(bReqReady), 32'd0);
            checkOutput($sformatf("B_memRaddr%0d", k), bMemRaddr, 32'h80000008);
            checkOutput($sformatf("B_memWdata%0d", k), bMemWdata, 32'h0BADF00D);
            checkOutput($sformatf("B_memWmask%0d", k), 32'(bMemWmask), 32'h0F);
            @(posedge clock); #1;
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("B_holdValid%0d", k), 32'(bRespValid), 32'd1);
            checkOutput($sformatf("B_holdRdata%0d", k), bRespRdata, 32'h0);
            checkOutput($sformatf("B_holdErr%0d", k), 32'(bRespErr), 32'd0);
            checkOutput($sformatf("B_holdReqReady%0d", k), 32'(bReqReady), 32'd0);
            checkOutput($sformatf("B_holdMemValid%0d", k), 32'(bMemValid), 32'd0);
            @(posedge clock); #1;
        end
        bRespReady = 1'b1;
        @(posedge clock); #1;
        bRespReady = 1'b0;
        checkOutput("B_reqReadyBack", 32'(bReqReady), 32'd1);
        checkOutput("B_respDropped", 32'(bRespValid), 32'd0);
        checkOutput("B_respQueueEmpty", 32'(bRespQ.size()), 32'd0);

        // DUT B: reset during ACCESS drops the store with no response
        bReqValid = 1'b1; bReqWen = 1'b1; bReqAddr = 32'h8000000C; bReqWdata = 32'hCAFEBABE;
        bReqSize = SIZE_W;
        @(posedge clock); #1;
        bReqValid = 1'b0;
        checkOutput("B_rstInAccess", 32'(bMemValid), 32'd1);
        bReset = 1'b1; bRespReady = 1'b1;
        @(posedge clock); #1;
        checkOutput("B_rstMemValid", 32'(bMemValid), 32'd0);
        checkOutput("B_rstMemWen", 32'(bMemWen), 32'd0);
        checkOutput("B_rstRespValid", 32'(bRespValid), 32'd0);
        bReset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            checkOutput($sformatf("B_postRstReady%0d", k), 32'(bReqReady), 32'd1);
            checkOutput($sformatf("B_postRstResp%0d", k), 32'(bRespValid), 32'd0);
            checkOutput($sformatf("B_postRstWen%0d", k), 32'(bMemWen), 32'd0);
        end
        bRespReady = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
